// File: rtl/tt_proc_pkg.sv
// tt_proc_pkg: opcodes, mode encodings and FSM states for the parametrised processor
package tt_proc_pkg;

    localparam logic [2:0] OP_LDI = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_IN  = 3'd5;
    localparam logic [2:0] OP_OUT = 3'd6;
    localparam logic [2:0] OP_SYS = 3'd7;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b10;
    localparam logic [1:0] MODE_STEP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // sign-extend the 3-bit branch offset field
    function automatic logic [7:0] sext3(input logic [2:0] f);
        return {{5{f[2]}}, f};
    endfunction

endpackage

// File: rtl/tt_proc_strobe_sync.sv
// tt_proc_strobe_sync: 2-FF synchroniser for mode bits and strobe, plus strobe rising-edge detect
module tt_proc_strobe_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] mode_raw,
    input  logic       strobe_raw,
    output logic [1:0] mode,
    output logic       strobe
);

    logic [2:0] s1, s2;
    logic       s3;

    // two-stage sync, third stage remembers the previous synced strobe level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= 1'b0;
        end else if (ena) begin
            s1 <= {mode_raw, strobe_raw};
            s2 <= s1;
            s3 <= s2[0];
        end
    end

    assign mode   = s2[2:1];
    assign strobe = s2[0] & ~s3;

endmodule

// File: rtl/tt_um_proc_param.sv
// tt_um_proc_param: serially loaded 8-bit-ISA processor with IDLE/LOAD/RUN/STEP/HALT control
module tt_um_proc_param
    import tt_proc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PROG_DEPTH = 16
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int PC_W = $clog2(PROG_DEPTH);

    logic [1:0]        mode;
    logic              strobe;
    state_t            state;
    logic [7:0]        prog [PROG_DEPTH];
    logic [DATA_W-1:0] regs [4];
    logic [PC_W-1:0]   pc, load_ptr, pc_next;
    logic [DATA_W-1:0] out_reg, a, b, res;
    logic [DATA_W:0]   sum, diff;
    logic              carry, zero;
    logic [7:0]        insn;
    logic [2:0]        op, f;
    logic [1:0]        rd;
    logic              retire, is_halt, wr_reg, arith;

    tt_proc_strobe_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .mode_raw   (ui_in[7:6]),
        .strobe_raw (ui_in[0]),
        .mode       (mode),
        .strobe     (strobe)
    );

    assign insn    = prog[pc];
    assign op      = insn[7:5];
    assign rd      = insn[4:3];
    assign f       = insn[2:0];
    assign a       = regs[rd];
    assign b       = regs[f[1:0]];
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign is_halt = op == OP_SYS && rd == 2'd0;
    assign wr_reg  = op < OP_OUT;
    assign arith   = op == OP_ADD || op == OP_SUB;
    assign retire  = state == ST_RUN && (mode == MODE_RUN || (mode == MODE_STEP && strobe));

    // ALU result and next pc for the instruction at pc
    always_comb begin
        res = op == OP_LDI ? DATA_W'(f) :
              op == OP_ADD ? sum[DATA_W-1:0] :
              op == OP_SUB ? diff[DATA_W-1:0] :
              op == OP_AND ? a & b :
              op == OP_XOR ? a ^ b : DATA_W'(ui_in[5:0]);
        pc_next = (op == OP_SYS && a != '0) ? pc + PC_W'(1) + PC_W'(sext3(f)) : pc + PC_W'(1);
    end

    // control FSM, program RAM, register file and flags; a transition swallows any same-cycle strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc       <= '0;
            load_ptr <= '0;
            out_reg  <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            for (int i = 0; i < PROG_DEPTH; i++) prog[i] <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (mode == MODE_LOAD) begin
                        state    <= ST_LOAD;
                        load_ptr <= '0;
                        pc       <= '0;
                    end else if (mode[1]) state <= ST_RUN;
                end
                ST_LOAD: begin
                    if (mode == MODE_IDLE) state <= ST_IDLE;
                    else if (mode[1]) state <= ST_RUN;
                    else if (strobe) begin
                        prog[load_ptr] <= uio_in;
                        load_ptr       <= load_ptr + PC_W'(1);
                    end
                end
                ST_RUN: begin
                    if (mode == MODE_IDLE) state <= ST_IDLE;
                    else if (mode == MODE_LOAD) begin
                        state    <= ST_LOAD;
                        load_ptr <= '0;
                        pc       <= '0;
                    end else if (retire) begin
                        if (is_halt) state <= ST_HALT;
                        else begin
                            pc <= pc_next;
                            if (wr_reg) begin
                                regs[rd] <= res;
                                zero     <= res == '0;
                            end
                            if (arith) carry <= op == OP_SUB ? diff[DATA_W] : sum[DATA_W];
                            if (op == OP_OUT) out_reg <= a;
                        end
                    end
                end
                default: begin
                    if (mode == MODE_IDLE) state <= ST_IDLE;
                    else if (mode == MODE_LOAD) begin
                        state    <= ST_LOAD;
                        load_ptr <= '0;
                        pc       <= '0;
                    end
                end
            endcase
        end
    end

    assign uo_out  = 8'(out_reg);
    assign uio_out = {state, carry, zero, 4'(pc)};
    assign uio_oe  = state == ST_LOAD ? 8'h00 : 8'hFF;

endmodule

// File: tb/tb_tt_um_proc_param.sv
// tb_tt_um_proc_param: table-driven program vectors plus directed multi-cycle sequences
module tb_tt_um_proc_param;

    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
    logic       ena, clk, rst_n;
    int         applied = 0;
    int         miscompares = 0;

    typedef struct {
        string        name;
        logic [127:0] prog;
        int           n;
        logic [5:0]   in_val;
        logic [7:0]   uo;
        logic [7:0]   uio;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] seen [$];
    logic [7:0] last;

    tt_um_proc_param dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic step_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        step_clk(2);
        rst_n = 1'b1;
        step_clk(2);
    endtask

    task automatic set_mode(input logic [1:0] m);
        ui_in[7:6] = m;
        step_clk(4);
    endtask

    task automatic pulse();
        ui_in[0] = 1'b1;
        step_clk(4);
        ui_in[0] = 1'b0;
        step_clk(3);
    endtask

    task automatic load(input logic [127:0] p, input int n);
        set_mode(2'b01);
        for (int i = 0; i < n; i++) begin
            uio_in = p[127-8*i -: 8];
            pulse();
        end
    endtask

    task automatic run_to_halt(input string name, input logic [5:0] in_val);
        bit done = 0;
        set_mode(2'b00);
        ui_in = {2'b10, in_val};
        for (int i = 0; i < 300 && !done; i++) begin
            step_clk(1);
            done = uio_out[7:6] == 2'b11;
        end
        if (!done) begin
            applied++;
            miscompares++;
            $display("FAIL %s: timeout, state %0d, expected HALT", name, uio_out[7:6]);
        end
    endtask

    initial begin
        vecs[0] = '{"add",      {8'h0D,8'h13,8'h2A,8'hC8,8'hE0,88'h0},       5,  6'h00, 8'h08, 8'hC4};
        vecs[1] = '{"loop",     {8'h0B,8'h11,8'h4A,8'hC8,8'hED,8'hE0,80'h0}, 6,  6'h00, 8'h00, 8'hD5};
        vecs[2] = '{"in_add3",  {8'hA8,8'h29,8'h29,8'h29,8'hC8,8'hE0,80'h0}, 6,  6'h3F, 8'hF8, 8'hE5};
        vecs[3] = '{"in_add4",  {8'hA8,8'h29,8'h29,8'h29,8'h29,8'hC8,8'hE0,72'h0}, 7, 6'h3F, 8'hF0, 8'hE6};
        vecs[4] = '{"and",      {8'h0F,8'h15,8'h6A,8'hC8,8'hE0,88'h0},       5,  6'h00, 8'h05, 8'hC4};
        vecs[5] = '{"xor",      {8'h0F,8'h15,8'h8A,8'hC8,8'hE0,88'h0},       5,  6'h00, 8'h02, 8'hC4};
        vecs[6] = '{"sub_brw",  {8'h09,8'h12,8'h4A,8'hC8,8'hE0,88'h0},       5,  6'h00, 8'hFF, 8'hE4};
        vecs[7] = '{"bnz_wrap", {8'h09,8'hEC,96'h0,8'hC8,8'hE0},             16, 6'h00, 8'h01, 8'hCF};
        vecs[8] = '{"nop_halt", {8'h00,8'h00,8'hE0,104'h0},                  3,  6'h00, 8'h00, 8'hD2};

        do_reset();
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'hFF);

        for (int v = 0; v < 9; v++) begin
            do_reset();
            load(vecs[v].prog, vecs[v].n);
            run_to_halt(vecs[v].name, vecs[v].in_val);
            chk({vecs[v].name, "_uo"}, uo_out, vecs[v].uo);
            chk({vecs[v].name, "_uio"}, uio_out, vecs[v].uio);
        end

        // branch loop: uo_out must step through 02, 01, 00 before halting
        do_reset();
        load({8'h0B,8'h11,8'h4A,8'hC8,8'hED,8'hE0,80'h0}, 6);
        set_mode(2'b00);
        last = uo_out;
        ui_in = 8'h80;
        for (int i = 0; i < 300 && uio_out[7:6] != 2'b11; i++) begin
            step_clk(1);
            if (uo_out != last) seen.push_back(uo_out);
            last = uo_out;
        end
        chk("seq_len", 8'(seen.size()), 8'd3);
        chk("seq_0", seen.size() > 0 ? seen[0] : 8'hXX, 8'h02);
        chk("seq_1", seen.size() > 1 ? seen[1] : 8'hXX, 8'h01);
        chk("seq_2", seen.size() > 2 ? seen[2] : 8'hXX, 8'h00);

        // single-step: three strobes reach pc=3, the fourth executes OUT
        do_reset();
        load({8'h0D,8'h13,8'h2A,8'hC8,8'hE0,88'h0}, 5);
        set_mode(2'b00);
        set_mode(2'b11);
        chk("step_pc0", uio_out, 8'h80);
        repeat (3) pulse();
        chk("step_pc3", {4'h0, uio_out[3:0]}, 8'h03);
        chk("step_st", {6'h0, uio_out[7:6]}, 8'h02);
        chk("step_uo3", uo_out, 8'h00);
        pulse();
        chk("step_uo4", uo_out, 8'h08);
        pulse();
        chk("step_halt", uio_out, 8'hC4);

        // load wrap: 17th word lands in prog[0]
        do_reset();
        set_mode(2'b01);
        chk("load_oe", uio_oe, 8'h00);
        chk("load_uio", uio_out, 8'h40);
        load({8'hE0,8'hC8,8'hE0,104'h0}, 16);
        uio_in = 8'h0F;
        pulse();
        run_to_halt("wrap", 6'h00);
        chk("wrap_uo", uo_out, 8'h07);
        chk("wrap_uio", uio_out, 8'hC2);
        chk("wrap_oe", uio_oe, 8'hFF);

        // freeze: loop LDI r1,1 / OUT r1 / BNZ r1,-2; after 10 edges 7 instructions retired, pc=1
        do_reset();
        load({8'h09,8'hC8,8'hEE,104'h0}, 3);
        set_mode(2'b00);
        ui_in = 8'h80;
        step_clk(10);
        chk("pre_frz_uio", uio_out, 8'h81);
        chk("pre_frz_uo", uo_out, 8'h01);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_clk(1);
            chk("frz_uio", uio_out, 8'h81);
            chk("frz_uo", uo_out, 8'h01);
        end
        ena = 1'b1;
        step_clk(1);
        chk("unfrz_uio", uio_out, 8'h82);

        // asynchronous reset mid-run, observed before the next clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("arst_uo", uo_out, 8'h00);
        chk("arst_uio", uio_out, 8'h00);
        chk("arst_oe", uio_oe, 8'hFF);
        step_clk(2);
        rst_n = 1'b1;
        step_clk(2);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
